weight_loader: RTL
==================

# weight_loader

Upstream feeder for the per-OCU weight buffer. It accepts ternary weights as a narrow valid/ready beat stream and assembles them into a full K×K×N_I staging register. On a controller commit, it presents the complete kernel on `data_o` and raises a one-cycle `save_enable_o` pulse that loads the downstream weight buffer. The block sits between the weight-memory read port and the weight buffer of each output-channel compute unit.

## Interface
Parameters:
- `N_I`, 512, input channels per kernel tap.
- `K`, 3, kernel side length; K*K taps per kernel.
- `N_PER_BEAT`, 64, ternary values per input beat; N_I % N_PER_BEAT == 0 is required and is checked at elaboration.

Ports:
- `clk_i` in 1: clock; the block has one clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `flush_i` in 1: synchronous clear of the staging register, counters and state.
- `in_valid_i` in 1: input beat valid.
- `in_ready_o` out 1: loader can accept a beat.
- `in_data_i` in [0:N_PER_BEAT-1][1:0]: ternary codes; 00 = 0, 01 = +1, 11 = −1, 10 = illegal.
- `commit_i` in 1: controller reports the downstream buffer may be overwritten.
- `full_o` out 1: complete kernel staged and waiting for commit.
- `save_enable_o` out 1: one-cycle load strobe to the weight buffer.
- `data_o` out [0:K-1][0:K-1][0:N_I-1][1:0]: staged kernel.
- `error_o` out 1: sticky illegal-code flag (see Configuration).

## Operation
- Two counters:
  - `chunk`, range 0..N_I/N_PER_BEAT−1.
  - `tap`, range 0..K*K−1, with kh = tap/K and kw = tap%K.
- A beat is accepted when `in_valid_i && in_ready_o` at a rising edge.
  - It writes channels chunk*N_PER_BEAT .. chunk*N_PER_BEAT+N_PER_BEAT−1 of tap (kh,kw).
  - `chunk` then increments; when it wraps to 0, `tap` increments.
- Total beats per kernel: K*K*N_I/N_PER_BEAT (72 with defaults).
- FSM states:
  - FILL: `in_ready_o` = 1. The last beat (tap = K*K−1, chunk max) moves to FULL and wraps both counters to 0.
  - FULL: `in_ready_o` = 0 and `full_o` = 1. When `commit_i` = 1 at an edge: return to FILL and set `save_enable_o` = 1 for exactly the next cycle.
- `data_o` is driven directly from the staging register.
  - Beats accepted during the pulse cycle update staging at the same edge the buffer samples, so the buffer captures the old kernel.
  - Back-to-back refill is therefore legal.
- `commit_i` in FILL is ignored, with no pulse.
- `flush_i` has priority over every other event:
  - Next state FILL, counters 0, staging 0, `save_enable_o` 0.
  - The beat offered that cycle is dropped; `in_ready_o` stays 1 but the beat is not written.
  - `error_o` is cleared.
- `flush_i` together with `commit_i` in FULL produces no pulse.

## Timing
- Reset values: state FILL, counters 0, `data_o` 0, `save_enable_o` 0, `full_o` 0, `in_ready_o` 1, `error_o` 0.
- Asserting `rst_i` mid-kernel discards partial data immediately (asynchronous).
- `in_ready_o` and `full_o` are decoded from state only, with no combinational path from `in_valid_i`.
- Latency:
  - Last-beat edge E → `full_o` high after E.
  - Earliest commit edge is E+1 → `save_enable_o` high for the cycle E+1..E+2.
- `save_enable_o` is registered, glitch-free, and never high for two consecutive cycles.

## Configuration
- `WEIGHT_LOADER_ENC_CHECK_EN` defined:
  - Every accepted beat is checked for code 10.
  - Any occurrence sets `error_o`, which stays set until `flush_i` or reset.
  - Illegal codes are written as 00.
- Not defined: codes are stored unmodified and `error_o` is tied to 0.

## Structure
- Shared package holds:
  - `weight_t` (2-bit ternary code) with localparams `W_ZERO`, `W_POS`, `W_NEG`, `W_ILLEGAL`.
  - The loader state enum.
  - Function `beats_per_kernel(N_I, K, N_PER_BEAT)`.
- One sub-module, `weight_loader_addr`, holds the chunk/tap counters with wrap logic. It exposes `last_beat` and the write-enable decode for the staging register.

## Test plan
- Defaults, 72 beats streamed with no stalls, channel value = index%3 mapped to 0/+1/−1 → `full_o` after beat 72; commit → one `save_enable_o` cycle with `data_o` matching the golden kernel bit-exactly.
- Random `in_valid_i` gaps, commit held high before fill completes → no pulse before FULL; exactly one pulse after it; `in_ready_o` stays low in FULL for 20 idle cycles.
- Refill of kernel B starting in the pulse cycle of kernel A → the buffer model holds A; after the next commit it holds B.
- `flush_i` at beat 30, then a full 72-beat load → the kernel contains only post-flush data; no pulse is produced from the aborted fill.
- `rst_i` pulsed asynchronously mid-cycle while FULL → all outputs return to reset values before the next edge.
- With `WEIGHT_LOADER_ENC_CHECK_EN`: beat 5 carries code 10 in channel 3 → `error_o` is 1 from the next edge, that position is stored as 00, and `error_o` clears only on `flush_i`.

Source files
------------

// File: rtl/weight_loader_pkg.sv
// ============================================================================
// Module      : weight_loader_pkg
// Description : Shared types, ternary code constants and loader state encoding
//               for the weight loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package weight_loader_pkg;

   typedef logic [1:0] weight_t;

   localparam weight_t W_ZERO    = 2'b00;
   localparam weight_t W_POS     = 2'b01;
   localparam weight_t W_NEG     = 2'b11;
   localparam weight_t W_ILLEGAL = 2'b10;

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } loader_state_e;

   function automatic int beats_per_kernel(input int n_i, input int k, input int n_per_beat);
      return (k * k * n_i) / n_per_beat;
   endfunction

endpackage

`default_nettype wire

// File: rtl/weight_loader_if.sv
// ============================================================================
// Module      : weight_loader_if
// Description : Beat stream, controller handshake and staged-kernel bus of the
//               weight loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface weight_loader_if #(
   parameter int N_I        = 512,
   parameter int K          = 3,
   parameter int N_PER_BEAT = 64
) ();

   logic                                                    flush_i;
   logic                                                    in_valid_i;
   logic                                                    in_ready_o;
   weight_loader_pkg::weight_t [0:N_PER_BEAT-1]             in_data_i;
   logic                                                    commit_i;
   logic                                                    full_o;
   logic                                                    save_enable_o;
   weight_loader_pkg::weight_t [0:K-1][0:K-1][0:N_I-1]      data_o;
   logic                                                    error_o;

   modport master (
      output flush_i, in_valid_i, in_data_i, commit_i,
      input  in_ready_o, full_o, save_enable_o, data_o, error_o
   );

   modport slave (
      input  flush_i, in_valid_i, in_data_i, commit_i,
      output in_ready_o, full_o, save_enable_o, data_o, error_o
   );

endinterface

`default_nettype wire

// File: rtl/weight_loader_addr.sv
// ============================================================================
// Module      : weight_loader_addr
// Description : Chunk/tap write counters with wrap, last-beat flag and one-hot
//               write-enable decode for the staging register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_loader_addr
   import weight_loader_pkg::*;
#(
   parameter int N_I        = 512,
   parameter int K          = 3,
   parameter int N_PER_BEAT = 64
) (
   input  wire logic                      clk_i,
   input  wire logic                      rst_i,
   input  wire logic                      flush_i,
   input  wire logic                      accept_i,
   output      logic                      last_beat_o,
   output      logic [K*K-1:0]            tap_we_o,
   output      logic [N_I/N_PER_BEAT-1:0] chunk_sel_o
);

   localparam int c_N_CHUNK = beats_per_kernel(N_I, 1, N_PER_BEAT);
   localparam int c_N_TAP   = K * K;
   localparam int c_CHUNK_W = (c_N_CHUNK > 1) ? $clog2(c_N_CHUNK) : 1;
   localparam int c_TAP_W   = (c_N_TAP > 1) ? $clog2(c_N_TAP) : 1;

   localparam logic [c_CHUNK_W-1:0] c_CHUNK_MAX = c_CHUNK_W'(c_N_CHUNK - 1);
   localparam logic [c_TAP_W-1:0]   c_TAP_MAX   = c_TAP_W'(c_N_TAP - 1);

   logic [c_CHUNK_W-1:0] r_chunk;
   logic [c_TAP_W-1:0]   r_tap;
   logic                 w_chunk_last;
   logic                 w_tap_last;

   assign w_chunk_last = (r_chunk == c_CHUNK_MAX);
   assign w_tap_last   = (r_tap == c_TAP_MAX);
   assign last_beat_o  = w_chunk_last && w_tap_last;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_chunk <= '0;
         r_tap   <= '0;
      end else if (flush_i) begin
         r_chunk <= '0;
         r_tap   <= '0;
      end else if (accept_i) begin
         if (w_chunk_last) begin
            r_chunk <= '0;
            r_tap   <= w_tap_last ? '0 : r_tap + c_TAP_W'(1);
         end else begin
            r_chunk <= r_chunk + c_CHUNK_W'(1);
         end
      end
   end

   // Tap enables carry the accept qualifier; chunk selects are pure decodes.
   for (genvar t = 0; t < c_N_TAP; t++) begin : g_tap_dec
      assign tap_we_o[t] = accept_i && (r_tap == c_TAP_W'(t));
   end

   for (genvar c = 0; c < c_N_CHUNK; c++) begin : g_chunk_dec
      assign chunk_sel_o[c] = (r_chunk == c_CHUNK_W'(c));
   end

endmodule

`default_nettype wire

// File: rtl/weight_loader.sv
// ============================================================================
// Module      : weight_loader
// Description : Assembles ternary weight beats into a K x K x N_I staging
//               register and strobes it into the weight buffer on commit.
//               Optional illegal-code check: WEIGHT_LOADER_ENC_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_loader
   import weight_loader_pkg::*;
#(
   parameter int N_I        = 512,
   parameter int K          = 3,
   parameter int N_PER_BEAT = 64
) (
   input wire logic        clk_i,
   input wire logic        rst_i,
   weight_loader_if.slave  bus
);

   localparam int c_N_CHUNK = beats_per_kernel(N_I, 1, N_PER_BEAT);
   localparam int c_N_TAP   = K * K;

   if (N_I % N_PER_BEAT != 0) begin : g_cfg_check
      $error("weight_loader: N_I must be a multiple of N_PER_BEAT");
   end

   loader_state_e                   r_state;
   loader_state_e                   w_state_nxt;
   logic                            r_save_en;
   logic                            w_save_nxt;
   logic                            w_ready;
   logic                            w_accept;
   logic                            w_last_beat;
   logic [c_N_TAP-1:0]              w_tap_we;
   logic [c_N_CHUNK-1:0]            w_chunk_sel;
   weight_t [0:N_PER_BEAT-1]        w_beat;
   weight_t [0:K-1][0:K-1][0:N_I-1] r_staging;

   // Ready depends on state only; flush drops the offered beat.
   assign w_ready  = (r_state == ST_FILL);
   assign w_accept = bus.in_valid_i && w_ready && !bus.flush_i;

   weight_loader_addr #(
      .N_I        (N_I),
      .K          (K),
      .N_PER_BEAT (N_PER_BEAT)
   ) u_addr (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (bus.flush_i),
      .accept_i    (w_accept),
      .last_beat_o (w_last_beat),
      .tap_we_o    (w_tap_we),
      .chunk_sel_o (w_chunk_sel)
   );

`ifdef WEIGHT_LOADER_ENC_CHECK_EN
   logic [N_PER_BEAT-1:0] w_illegal;
   logic                  r_error;

   for (genvar j = 0; j < N_PER_BEAT; j++) begin : g_enc_check
      assign w_illegal[j] = (bus.in_data_i[j] == W_ILLEGAL);
      assign w_beat[j]    = w_illegal[j] ? W_ZERO : bus.in_data_i[j];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_error <= 1'b0;
      end else if (bus.flush_i) begin
         r_error <= 1'b0;
      end else if (w_accept && (|w_illegal)) begin
         r_error <= 1'b1;
      end
   end

   assign bus.error_o = r_error;
`else
   assign w_beat      = bus.in_data_i;
   assign bus.error_o = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_FILL;
         r_save_en <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_save_en <= w_save_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_save_nxt  = 1'b0;
      if (bus.flush_i) begin
         w_state_nxt = ST_FILL;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (w_accept && w_last_beat) begin
                  w_state_nxt = ST_FULL;
               end
            end
            ST_FULL: begin
               if (bus.commit_i) begin
                  w_state_nxt = ST_FILL;
                  w_save_nxt  = 1'b1;
               end
            end
            default: w_state_nxt = ST_FILL;
         endcase
      end
   end

   // Writes during the save pulse land on the same edge the buffer samples,
   // so the buffer always captures the previous kernel.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_staging <= '0;
      end else if (bus.flush_i) begin
         r_staging <= '0;
      end else begin
         for (int t = 0; t < c_N_TAP; t++) begin
            for (int c = 0; c < c_N_CHUNK; c++) begin
               if (w_tap_we[t] && w_chunk_sel[c]) begin
                  for (int j = 0; j < N_PER_BEAT; j++) begin
                     r_staging[t / K][t % K][c * N_PER_BEAT + j] <= w_beat[j];
                  end
               end
            end
         end
      end
   end

   assign bus.in_ready_o    = w_ready;
   assign bus.full_o        = (r_state == ST_FULL);
   assign bus.save_enable_o = r_save_en;
   assign bus.data_o        = r_staging;

endmodule

`default_nettype wire
